alu_mul_sequencer: RTL and testbench
====================================

// Module: alu_mul_sequencer
// PURPOSE
//   Iterative shift-add multiplier that time-shares the single datapath ALU.
//   While idle, the datapath's ALU controls and operands pass straight through to the ALU.
//   On start, it takes the ALU for WIDTH cycles, issues add ops (ALUctr 4'b0010), and
//   accumulates a 2*WIDTH-bit unsigned product. It stalls the datapath while busy.
// PARAMETERS
//   WIDTH    32   operand width; product is 2*WIDTH bits
//   CNT_W    6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk          in   1        clock, rising edge
//   reset        in   1        synchronous, active-high
//   start        in   1        1-cycle pulse; accepted only in IDLE
//   mcand        in   WIDTH    multiplicand, sampled on accepted start
//   mplier       in   WIDTH    multiplier, sampled on accepted start
//   dp_alu_ctr   in   4        datapath ALUctr, passed through when not RUN
//   dp_alu_a     in   WIDTH    datapath ALU operand A, passed through when not RUN
//   dp_alu_b     in   WIDTH    datapath ALU operand B, passed through when not RUN
//   alu_sum      in   WIDTH    ALU result, returned from the shared ALU
//   alu_cout     in   1        ALU carry-out of the add
//   alu_ctr      out  4        ALUctr driven to the shared ALU
//   alu_a        out  WIDTH    operand A to the shared ALU
//   alu_b        out  WIDTH    operand B to the shared ALU
//   busy         out  1        high in RUN and DONE; datapath must hold its PC/regs
//   done         out  1        1-cycle pulse; product valid
//   product_hi   out  WIDTH    upper half of product
//   product_lo   out  WIDTH    lower half of product
// BEHAVIOUR
//   - Reset: state=IDLE, count=0, product_hi=product_lo=0, mcand_r=0, busy=0, done=0.
//   - Reset wins over start in the same cycle.
//   - States: IDLE -> RUN on start. RUN -> DONE after WIDTH iterations. DONE -> IDLE, always.
//   - IDLE, start=1:
//       - Latch mcand_r<=mcand.
//       - Load {P_hi,P_lo}<={0,mplier}.
//       - Set count<=0.
//   - RUN, each cycle:
//       - Drive alu_ctr=4'b0010, alu_a=P_hi.
//       - Drive alu_b = P_lo[0] ? mcand_r : 0.
//       - Update {P_hi,P_lo} <= {alu_cout,alu_sum,P_lo[WIDTH-1:1]}, i.e. a right shift with carry in.
//       - count++. Exit to DONE when count==WIDTH-1.
//   - DONE: done=1 for exactly one cycle, busy=1, ALU back on pass-through.
//   - Latency: start accepted at cycle 0 -> done high at cycle WIDTH+1.
//     busy is high in cycles 1..WIDTH+1.
//   - Outputs:
//       - product_hi/lo reflect P_hi/P_lo at all times.
//       - They are final and held from DONE until the next accepted start.
//   - ALU mux:
//       - alu_ctr/alu_a/alu_b = dp_* in IDLE and DONE. Combinational, no added latency.
//       - Sequencer drives them in RUN.
//   - start while busy: ignored, no effect on state or operands.
//   - Reset mid-RUN: abort to IDLE next edge. Product cleared, no done pulse.
//   - Arithmetic: unsigned only. The carry-out is kept each step, so no overflow is lost.
//     count wraps are impossible (2**CNT_W > WIDTH).
// CONFIGURATION
//   ALU_MUL_ZERO_SKIP_EN
//     defined:
//       - Accepted start with mcand==0 or mplier==0 goes IDLE -> DONE directly.
//       - Product is loaded as 0; done is high at cycle 1; RUN is never entered.
//       - The ALU stays on pass-through throughout.
//     undefined:
//       - Every accepted start runs the full WIDTH RUN cycles, regardless of operand values.
// TESTING
//   1. reset 2 cycles, idle: dp_alu_ctr=4'b0110, dp_a=9, dp_b=4 -> alu_ctr=0110, alu_a=9, alu_b=4,
//      busy=0, done=0, product=0.
//   2. start, mcand=3, mplier=5 -> busy at cycle 1, alu_ctr=0010 cycles 1..32,
//      done at cycle 33, product_hi=0, product_lo=15.
//   3. mcand=mplier=32'hFFFFFFFF -> done at cycle 33, product_hi=32'hFFFFFFFE, product_lo=32'h00000001.
//   4. start pulsed again at cycle 10 of test 2 with mcand=7 -> ignored, result still 15 at cycle 33.
//   5. reset asserted at cycle 12 of a run -> next cycle IDLE, busy=0, product=0,
//      no done pulse, pass-through restored.
//   6. mcand=0, mplier=9:
//      - with ALU_MUL_ZERO_SKIP_EN: done at cycle 1, product=0.
//      - without: done at cycle 33, product=0.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: iterative shift-add unsigned multiplier that borrows the
// shared datapath ALU for WIDTH add cycles and stalls the datapath while busy.
// Optional feature macro: ALU_MUL_ZERO_SKIP_EN -- when defined, a start with a
// zero operand jumps straight to DONE with a zero product and never takes the ALU.
module alu_mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] mcand,
    input  logic [WIDTH-1:0] mplier,
    input  logic [3:0]       dp_alu_ctr,
    input  logic [WIDTH-1:0] dp_alu_a,
    input  logic [WIDTH-1:0] dp_alu_b,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic             alu_cout,
    output logic [3:0]       alu_ctr,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [3:0]       ALU_ADD   = 4'b0010;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] phi_q, phi_d;
    logic [WIDTH-1:0] plo_q, plo_d;
    logic             startAcc;
    logic             zeroOp;

    assign startAcc = (state_q == IDLE) && start;

`ifdef ALU_MUL_ZERO_SKIP_EN
    assign zeroOp = (mcand == '0) || (mplier == '0);
`else
    assign zeroOp = 1'b0;
`endif

    // State register; reset aborts any run and returns to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> RUN (or DONE on a skipped zero operand),
    // RUN -> DONE on the last iteration, DONE always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = zeroOp ? DONE : RUN;
            RUN:     if (count_q == LAST_ITER) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: the ALU is ours only in RUN; otherwise the datapath
    // controls pass straight through with no added latency.
    always_comb begin
        alu_ctr = dp_alu_ctr;
        alu_a   = dp_alu_a;
        alu_b   = dp_alu_b;
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        if (state_q == RUN) begin
            alu_ctr = ALU_ADD;
            alu_a   = phi_q;
            alu_b   = plo_q[0] ? mcand_q : '0;
        end
    end

    // Datapath next values: load operands on an accepted start, then each RUN
    // cycle shift the ALU sum (with its carry on top) right into the product.
    always_comb begin
        count_d = count_q;
        mcand_d = mcand_q;
        phi_d   = phi_q;
        plo_d   = plo_q;
        if (startAcc) begin
            mcand_d = mcand;
            phi_d   = '0;
            plo_d   = zeroOp ? '0 : mplier;
            count_d = '0;
        end else if (state_q == RUN) begin
            phi_d   = {alu_cout, alu_sum[WIDTH-1:1]};
            plo_d   = {alu_sum[0], plo_q[WIDTH-1:1]};
            count_d = count_q + 1'b1;
        end
    end

    // Datapath registers; the product halves are cleared by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            mcand_q <= '0;
            phi_q   <= '0;
            plo_q   <= '0;
        end else begin
            count_q <= count_d;
            mcand_q <= mcand_d;
            phi_q   <= phi_d;
            plo_q   <= plo_d;
        end
    end

    assign product_hi = phi_q;
    assign product_lo = plo_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Testbench for alu_mul_sequencer: a cycle-level behavioural model of the
// multiplier timing and arithmetic, checked every cycle, plus directed
// operations with hand-computed results.
module tb_alu_mul_sequencer;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;
    localparam int NONE  = -10;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [3:0]       dpCtr;
    logic [WIDTH-1:0] dpA;
    logic [WIDTH-1:0] dpB;
    logic [WIDTH-1:0] aluSum;
    logic             aluCout;
    logic [3:0]       aluCtr;
    logic [WIDTH-1:0] aluA;
    logic [WIDTH-1:0] aluB;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] productHi;
    logic [WIDTH-1:0] productLo;

    int errors = 0;
    int checks = 0;

    alu_mul_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mcand      (mcand),
        .mplier     (mplier),
        .dp_alu_ctr (dpCtr),
        .dp_alu_a   (dpA),
        .dp_alu_b   (dpB),
        .alu_sum    (aluSum),
        .alu_cout   (aluCout),
        .alu_ctr    (aluCtr),
        .alu_a      (aluA),
        .alu_b      (aluB),
        .busy       (busy),
        .done       (done),
        .product_hi (productHi),
        .product_lo (productLo)
    );

    // The shared ALU: an adder with carry-out.
    assign {aluCout, aluSum} = {1'b0, aluA} + {1'b0, aluB};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: mCnt is the cycle number since the accepted start
    // (0 = idle), mDoneAt the cycle where done must pulse.
    int          mCnt = 0;
    int          mDoneAt = WIDTH + 1;
    logic [63:0] mMc = '0;
    logic [63:0] mMp = '0;
    logic [63:0] mProd = '0;
    bit          mValid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mCnt   <= 0;
            mProd  <= '0;
            mValid <= 1'b1;
        end else if (mValid) begin
            if (mCnt == 0) begin
                if (start) begin
                    mMc     <= 64'(mcand);
                    mMp     <= 64'(mplier);
                    mProd   <= 64'(mcand) * 64'(mplier);
                    mDoneAt <= WIDTH + 1;
`ifdef ALU_MUL_ZERO_SKIP_EN
                    if (mcand == '0 || mplier == '0) mDoneAt <= 1;
`endif
                    mCnt    <= 1;
                end
            end else if (mCnt == mDoneAt) begin
                mCnt <= 0;
            end else begin
                mCnt <= mCnt + 1;
            end
        end
    end

    // Compare process: during run cycle k the ALU must be adding the partial
    // product of the low k-1 multiplier bits (shifted down) and, if multiplier
    // bit k-1 is set, the multiplicand. Outside the run the ALU passes through
    // and the product equals the full product of the last accepted operands.
    always @(negedge clk) begin
        if (mValid) begin
            logic        isRun;
            int          j;
            logic [63:0] partial;
            logic [63:0] mask;
            isRun = (mCnt >= 1) && (mCnt < mDoneAt);
            checkOutput("busy", 64'(busy), 64'(mCnt != 0));
            checkOutput("done", 64'(done), 64'((mCnt != 0) && (mCnt == mDoneAt)));
            if (isRun) begin
                j       = mCnt - 1;
                mask    = (64'd1 << j) - 64'd1;
                partial = mMc * (mMp & mask);
                checkOutput("runAluCtr", 64'(aluCtr), 64'(4'b0010));
                checkOutput("runAluA", 64'(aluA), 64'(32'(partial >> j)));
                checkOutput("runAluB", 64'(aluB), mMp[j] ? mMc : 64'd0);
            end else begin
                checkOutput("passCtr", 64'(aluCtr), 64'(dpCtr));
                checkOutput("passA", 64'(aluA), 64'(dpA));
                checkOutput("passB", 64'(aluB), 64'(dpB));
                checkOutput("product", {productHi, productLo}, mProd);
            end
        end
    end

    // One multiply: start at cycle 0, optionally pulse a stray start or a
    // reset mid-run, then check the done cycle and final product.
    task automatic applyStimulus(input string tag, input logic [31:0] mc, input logic [31:0] mp,
                                 input int pulseAt, input int resetAt, input int expDone,
                                 input logic [63:0] expProd);
        int   doneCyc;
        logic busyAt1;
        doneCyc = -1;
        busyAt1 = 1'b0;
        mcand   = mc;
        mplier  = mp;
        start   = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            start = (cyc == pulseAt);
            if (cyc == pulseAt) mcand = 32'd7;
            dpA = 32'(cyc * 3);
            dpB = ~32'(cyc);
            if (cyc == 1) busyAt1 = busy;
            if (done && doneCyc < 0) doneCyc = cyc;
            if (cyc == resetAt + 1) begin
                reset = 1'b0;
                checkOutput({tag, "_rstBusy"}, 64'(busy), 64'd0);
                checkOutput({tag, "_rstProduct"}, {productHi, productLo}, 64'd0);
                checkOutput({tag, "_rstPassCtr"}, 64'(aluCtr), 64'(dpCtr));
            end
            if (cyc == resetAt) reset = 1'b1;
        end
        checkOutput({tag, "_busyAt1"}, 64'(busyAt1), 64'd1);
        checkOutput({tag, "_doneCycle"}, 64'(doneCyc), 64'(expDone));
        checkOutput({tag, "_product"}, {productHi, productLo}, expProd);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        dpCtr  = 4'b0110;
        dpA    = 32'd9;
        dpB    = 32'd4;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        checkOutput("idleCtr", 64'(aluCtr), 64'(4'b0110));
        checkOutput("idleA", 64'(aluA), 64'd9);
        checkOutput("idleB", 64'(aluB), 64'd4);
        checkOutput("idleBusy", 64'(busy), 64'd0);
        checkOutput("idleDone", 64'(done), 64'd0);
        checkOutput("idleProduct", {productHi, productLo}, 64'd0);
        @(posedge clk);
        #1;

        applyStimulus("mul3x5", 32'd3, 32'd5, NONE, NONE, 33, 64'd15);
        applyStimulus("mulMax", 32'hFFFFFFFF, 32'hFFFFFFFF, NONE, NONE, 33, 64'hFFFFFFFE_00000001);
        applyStimulus("strayStart", 32'd3, 32'd5, 10, NONE, 33, 64'd15);
        applyStimulus("resetMid", 32'h1234_5678, 32'h0BAD_F00D, NONE, 12, -1, 64'd0);
`ifdef ALU_MUL_ZERO_SKIP_EN
        applyStimulus("zeroMcand", 32'd0, 32'd9, NONE, NONE, 1, 64'd0);
`else
        applyStimulus("zeroMcand", 32'd0, 32'd9, NONE, NONE, 33, 64'd0);
`endif
        applyStimulus("mulMixed", 32'h8000_0001, 32'h0000_0003, NONE, NONE, 33, 64'h00000001_80000003);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
